// File: rtl/rob_pkg.sv
// Shared widths and constants for the reorder buffer and its operand-resolve helper.
package rob_pkg;
  localparam int OPCODE_LENGTH = 5;
  localparam int DATA_LENGTH   = 31;
  localparam int PC_LENGTH     = 31;
  localparam int OP_W          = OPCODE_LENGTH + 1;
  localparam int DATA_W        = DATA_LENGTH + 1;
  localparam int TAG_W         = PC_LENGTH + 1;

  localparam logic [DATA_W-1:0] ZERO      = '0;
  localparam logic [TAG_W-1:0]  TAG_READY = '0;  // tag 0 means "value already valid"

  typedef struct packed {
    logic [DATA_W-1:0] v;
    logic [TAG_W-1:0]  q;
  } operand_t;

  function automatic logic [TAG_W-1:0] idx_to_tag(input logic [TAG_W-1:0] idx);
    return idx + 1'b1;
  endfunction
endpackage

// File: rtl/rob_operand_resolve.sv
// Resolves one source operand tag: ALU bypass first, then a ready ROB entry, else pass through.
module rob_operand_resolve
  import rob_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3
) (
  input  logic [TAG_W-1:0]              i_q,
  input  logic [DATA_W-1:0]             i_v,
  input  logic                          i_alu_valid,
  input  logic [TAG_W-1:0]              i_alu_tag,
  input  logic [DATA_W-1:0]             i_alu_data,
  input  logic [DEPTH-1:0]              i_ready,
  input  logic [DEPTH-1:0][DATA_W-1:0]  i_data,
  output operand_t                      o_opnd
);
  logic [IDX_W-1:0] w_idx;
  logic             w_in_range;

  assign w_idx      = IDX_W'(i_q - 1'b1);
  assign w_in_range = (i_q != TAG_READY) && (i_q <= TAG_W'(DEPTH));

  // NOTE: every output gets a default first so this block can never infer a latch.
  always_comb begin
    o_opnd.v = i_v;
    o_opnd.q = i_q;
    if (i_q != TAG_READY) begin
      if (i_alu_valid && (i_alu_tag == i_q)) begin
        o_opnd.v = i_alu_data;
        o_opnd.q = TAG_READY;
      end else if (w_in_range && i_ready[w_idx]) begin
        o_opnd.v = i_data[w_idx];
        o_opnd.q = TAG_READY;
      end
    end
  end
endmodule

// File: rtl/rob.sv
// Reorder buffer: allocates and renames incoming instructions, dispatches them to rs,
// collects ALU writebacks and commits in program order, flushing on an excepting commit.
module rob
  import rob_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              is_valid_from_iq,
  input  logic [OP_W-1:0]   op_from_iq,
  input  logic              is_sl_from_iq,
  input  logic [4:0]        rd_from_iq,
  input  logic [DATA_W-1:0] imm_from_iq,
  input  logic [DATA_W-1:0] pc_from_iq,
  input  logic [DATA_W-1:0] v1_from_reg,
  input  logic [DATA_W-1:0] v2_from_reg,
  input  logic [TAG_W-1:0]  q1_from_reg,
  input  logic [TAG_W-1:0]  q2_from_reg,
  input  logic              is_stall_from_rs,
  output logic              is_stall_to_instr_queue,
  output logic              is_empty_to_rs,
  output logic              is_sl_to_rs,
  output logic [OP_W-1:0]   op_to_rs,
  output logic [DATA_W-1:0] v1_to_rs,
  output logic [DATA_W-1:0] v2_to_rs,
  output logic [TAG_W-1:0]  q1_to_rs,
  output logic [TAG_W-1:0]  q2_to_rs,
  output logic [DATA_W-1:0] imm_to_rs,
  output logic [DATA_W-1:0] pc_to_rs,
  output logic              rename_valid_to_reg,
  output logic [4:0]        rd_to_reg,
  output logic [TAG_W-1:0]  tag_to_reg,
  input  logic              is_valid_from_alu,
  input  logic [TAG_W-1:0]  tag_from_alu,
  input  logic [DATA_W-1:0] data_from_alu,
  input  logic              is_exception_from_alu,
  output logic              is_commit_to_rs,
  output logic [TAG_W-1:0]  commit_pc_to_rs,
  output logic [DATA_W-1:0] commit_data_to_rs,
  output logic [4:0]        commit_rd_to_reg,
  output logic              is_exception_to_rs
);
  logic [IDX_W-1:0]             r_head, r_tail;
  logic [IDX_W:0]               r_count;
  logic [DEPTH-1:0]             r_valid, r_ready, r_exc;
  logic [DEPTH-1:0][4:0]        r_rd;
  logic [DEPTH-1:0][DATA_W-1:0] r_data;

  logic             w_commit, w_flush, w_alloc, w_wb_hit;
  logic [IDX_W-1:0] w_wb_idx;
  operand_t         w_op1, w_op2;

  assign is_stall_to_instr_queue = (r_count == (IDX_W+1)'(DEPTH)) | is_stall_from_rs;

  assign w_commit = r_valid[r_head] & r_ready[r_head];
  assign w_flush  = w_commit & r_exc[r_head];
  assign w_alloc  = is_valid_from_iq & ~is_stall_to_instr_queue & ~w_flush;
  assign w_wb_idx = IDX_W'(tag_from_alu - 1'b1);
  assign w_wb_hit = is_valid_from_alu && (tag_from_alu != TAG_READY) &&
                    (tag_from_alu <= TAG_W'(DEPTH)) && r_valid[w_wb_idx];

  rob_operand_resolve #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_res1 (
    .i_q(q1_from_reg), .i_v(v1_from_reg), .i_alu_valid(is_valid_from_alu),
    .i_alu_tag(tag_from_alu), .i_alu_data(data_from_alu),
    .i_ready(r_ready), .i_data(r_data), .o_opnd(w_op1)
  );

  rob_operand_resolve #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_res2 (
    .i_q(q2_from_reg), .i_v(v2_from_reg), .i_alu_valid(is_valid_from_alu),
    .i_alu_tag(tag_from_alu), .i_alu_data(data_from_alu),
    .i_ready(r_ready), .i_data(r_data), .o_opnd(w_op2)
  );

  // Later assignments win: writeback, then commit, then allocation, then flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_ready <= '0;
      r_exc   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_wb_hit) begin
        r_ready[w_wb_idx] <= 1'b1;
        r_exc[w_wb_idx]   <= r_exc[w_wb_idx] | is_exception_from_alu;
      end
      if (w_commit) r_valid[r_head] <= 1'b0;
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_ready[r_tail] <= 1'b0;
        r_exc[r_tail]   <= 1'b0;
      end
      if (w_flush) begin
        r_valid <= '0;
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_commit) r_head <= r_head + 1'b1;
        if (w_alloc)  r_tail <= r_tail + 1'b1;
        r_count <= r_count + (IDX_W+1)'(w_alloc) - (IDX_W+1)'(w_commit);
      end
    end
  end

  // NOTE: payload storage is not reset; an entry's valid bit gates every use of it.
  always_ff @(posedge clk) begin
    if (w_wb_hit) r_data[w_wb_idx] <= data_from_alu;
    if (w_alloc)  r_rd[r_tail]     <= rd_from_iq;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_empty_to_rs      <= 1'b1;
      is_sl_to_rs         <= 1'b0;
      op_to_rs            <= '0;
      v1_to_rs            <= ZERO;
      v2_to_rs            <= ZERO;
      q1_to_rs            <= TAG_READY;
      q2_to_rs            <= TAG_READY;
      imm_to_rs           <= ZERO;
      pc_to_rs            <= ZERO;
      rename_valid_to_reg <= 1'b0;
      rd_to_reg           <= '0;
      tag_to_reg          <= TAG_READY;
      is_commit_to_rs     <= 1'b0;
      commit_pc_to_rs     <= TAG_READY;
      commit_data_to_rs   <= ZERO;
      commit_rd_to_reg    <= '0;
      is_exception_to_rs  <= 1'b0;
    end else begin
      is_empty_to_rs      <= ~w_alloc;
      rename_valid_to_reg <= w_alloc;
      if (w_alloc) begin
        is_sl_to_rs <= is_sl_from_iq;
        op_to_rs    <= op_from_iq;
        v1_to_rs    <= w_op1.v;
        q1_to_rs    <= w_op1.q;
        v2_to_rs    <= w_op2.v;
        q2_to_rs    <= w_op2.q;
        imm_to_rs   <= imm_from_iq;
        pc_to_rs    <= pc_from_iq;
        rd_to_reg   <= rd_from_iq;
        tag_to_reg  <= idx_to_tag(TAG_W'(r_tail));
      end
      is_commit_to_rs    <= w_commit;
      is_exception_to_rs <= w_flush;
      if (w_commit) begin
        commit_pc_to_rs   <= idx_to_tag(TAG_W'(r_head));
        commit_data_to_rs <= r_data[r_head];
        commit_rd_to_reg  <= r_rd[r_head];
      end
    end
  end
endmodule
